// File: rtl/serial_issue_queue.sv
// In-order issue queue for serialising (CSR / privileged) instructions.
// Compacted multi-slot dispatch, CDB wakeup, oldest-first issue, optional one-in-flight gating.
module serial_issue_queue #(
  parameter int DEPTH     = 16,
  parameter int DISP_W    = 3,
  parameter int CDB_W     = 5,
  parameter int PTAG_W    = 6,
  parameter int ROB_W     = 6,
  parameter int PAY_W     = 24,
  parameter int SERIALIZE = 1,
  parameter int DONE_PORT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [DISP_W-1:0]            disp_valid,
  input  logic [2*DISP_W-1:0]          disp_src_used,
  input  logic [2*DISP_W*PTAG_W-1:0]   disp_src_tag,
  input  logic [2*DISP_W-1:0]          disp_src_rdy,
  input  logic [DISP_W*PTAG_W-1:0]     disp_pd,
  input  logic [DISP_W-1:0]            disp_regwr,
  input  logic [DISP_W*ROB_W-1:0]      disp_rob,
  input  logic [DISP_W*PAY_W-1:0]      disp_payload,
  input  logic                         disp_stall,
  output logic                         disp_full,
  output logic [$clog2(DEPTH):0]       count,
  input  logic [CDB_W-1:0]             cdb_valid,
  input  logic [CDB_W-1:0]             cdb_regwr,
  input  logic [CDB_W*PTAG_W-1:0]      cdb_tag,
  input  logic                         issue_stall,
  output logic                         issue_valid,
  output logic [ROB_W-1:0]             issue_rob,
  output logic [PTAG_W-1:0]            issue_pd,
  output logic                         issue_regwr,
  output logic [2*PTAG_W-1:0]          issue_src_tag,
  output logic [PAY_W-1:0]             issue_payload
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [DEPTH-1:0]  ent_vld;
  logic [DEPTH-1:0]  ent_regwr;
  logic [1:0]        ent_rdy [DEPTH];
  logic [PTAG_W-1:0] ent_tag [DEPTH][2];
  logic [PTAG_W-1:0] ent_pd  [DEPTH];
  logic [ROB_W-1:0]  ent_rob [DEPTH];
  logic [PAY_W-1:0]  ent_pay [DEPTH];

  ptr_t head, tail;
  logic inflight;

  cnt_t disp_cnt, free_slots;
  logic enq, issue_fire, head_rdy;
  ptr_t slot_ptr [DISP_W];
  logic [1:0] slot_rdy [DISP_W];
  ptr_t off;

  function automatic cnt_t popcnt(input logic [DISP_W-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < DISP_W; i++) c = c + cnt_t'(v[i]);
    return c;
  endfunction

  // Any CDB port writing a register with this tag
  function automatic logic cdb_hit(input logic [PTAG_W-1:0] tag,
                                   input logic [CDB_W-1:0] v,
                                   input logic [CDB_W-1:0] w,
                                   input logic [CDB_W*PTAG_W-1:0] t);
    logic h;
    h = 1'b0;
    for (int p = 0; p < CDB_W; p++)
      if (v[p] && w[p] && (t[p*PTAG_W +: PTAG_W] == tag)) h = 1'b1;
    return h;
  endfunction

  always_comb begin
    disp_cnt   = popcnt(disp_valid);
    free_slots = DEPTH_C - count;
    disp_full  = free_slots < disp_cnt;
    enq        = !flush && !disp_stall && !disp_full && (|disp_valid);
    head_rdy   = &ent_rdy[head];
    issue_fire = !flush && (count != '0) && head_rdy && !issue_stall &&
                 ((SERIALIZE == 0) || !inflight);
    off = '0;
    for (int s = 0; s < DISP_W; s++) begin
      slot_ptr[s] = tail + off;
      if (disp_valid[s]) off = off + ptr_t'(1);
      for (int j = 0; j < 2; j++)
        slot_rdy[s][j] = !disp_src_used[2*s+j] || disp_src_rdy[2*s+j] ||
                         cdb_hit(disp_src_tag[(2*s+j)*PTAG_W +: PTAG_W],
                                 cdb_valid, cdb_regwr, cdb_tag);
    end
  end

  // Entry payload and readiness; meaningful only while ent_vld is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i])
        for (int j = 0; j < 2; j++)
          if (cdb_hit(ent_tag[i][j], cdb_valid, cdb_regwr, cdb_tag)) ent_rdy[i][j] <= 1'b1;
    if (enq) begin
      for (int s = 0; s < DISP_W; s++) begin
        if (disp_valid[s]) begin
          ent_rdy[slot_ptr[s]]    <= slot_rdy[s];
          ent_tag[slot_ptr[s]][0] <= disp_src_tag[(2*s)*PTAG_W +: PTAG_W];
          ent_tag[slot_ptr[s]][1] <= disp_src_tag[(2*s+1)*PTAG_W +: PTAG_W];
          ent_pd[slot_ptr[s]]     <= disp_pd[s*PTAG_W +: PTAG_W];
          ent_regwr[slot_ptr[s]]  <= disp_regwr[s];
          ent_rob[slot_ptr[s]]    <= disp_rob[s*ROB_W +: ROB_W];
          ent_pay[slot_ptr[s]]    <= disp_payload[s*PAY_W +: PAY_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_vld     <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      issue_valid <= 1'b0;
    end else if (flush) begin
      ent_vld     <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      issue_valid <= 1'b0;
    end else begin
      if (issue_fire) begin
        ent_vld[head] <= 1'b0;
        head          <= head + ptr_t'(1);
      end
      if (enq) begin
        tail <= tail + ptr_t'(disp_cnt);
        for (int s = 0; s < DISP_W; s++)
          if (disp_valid[s]) ent_vld[slot_ptr[s]] <= 1'b1;
      end
      count <= count + (enq ? disp_cnt : cnt_t'(0)) - cnt_t'(issue_fire);
      // A done seen with nothing in flight falls through harmlessly
      if (issue_fire && (SERIALIZE != 0)) inflight <= 1'b1;
      else if (cdb_valid[DONE_PORT])      inflight <= 1'b0;
      issue_valid <= issue_fire;
    end
  end

  // Issue output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_rob     <= '0;
      issue_pd      <= '0;
      issue_regwr   <= 1'b0;
      issue_src_tag <= '0;
      issue_payload <= '0;
    end else if (issue_fire) begin
      issue_rob     <= ent_rob[head];
      issue_pd      <= ent_pd[head];
      issue_regwr   <= ent_regwr[head];
      issue_src_tag <= {ent_tag[head][1], ent_tag[head][0]};
      issue_payload <= ent_pay[head];
    end
  end

endmodule

// File: tb/tb_serial_issue_queue.sv
// Scoreboard bench for serial_issue_queue: a SERIALIZE=1 and a SERIALIZE=0 instance share stimulus.
module tb_serial_issue_queue;
  localparam int DISP_W = 3, CDB_W = 5, PTAG_W = 6, ROB_W = 6, PAY_W = 24;

  logic clk = 1'b0;
  logic rst, flush, disp_stall, issue_stall;
  logic [DISP_W-1:0] disp_valid, disp_regwr;
  logic [2*DISP_W-1:0] disp_src_used, disp_src_rdy;
  logic [2*DISP_W*PTAG_W-1:0] disp_src_tag;
  logic [DISP_W*PTAG_W-1:0] disp_pd;
  logic [DISP_W*ROB_W-1:0] disp_rob;
  logic [DISP_W*PAY_W-1:0] disp_payload;
  logic [CDB_W-1:0] cdb_valid, cdb_regwr;
  logic [CDB_W*PTAG_W-1:0] cdb_tag;

  logic disp_full, issue_valid, issue_regwr;
  logic [4:0] count;
  logic [ROB_W-1:0] issue_rob;
  logic [PTAG_W-1:0] issue_pd;
  logic [2*PTAG_W-1:0] issue_src_tag;
  logic [PAY_W-1:0] issue_payload;

  logic disp_full0, issue_valid0, issue_regwr0;
  logic [4:0] count0;
  logic [ROB_W-1:0] issue_rob0;
  logic [PTAG_W-1:0] issue_pd0;
  logic [2*PTAG_W-1:0] issue_src_tag0;
  logic [PAY_W-1:0] issue_payload0;

  int n_checks = 0, n_pass = 0;
  logic [ROB_W-1:0] exp_q[$];
  logic [ROB_W-1:0] exp0_q[$];
  logic [ROB_W-1:0] exp_rob;

  always #5 clk = ~clk;

  serial_issue_queue #(.SERIALIZE(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
    .disp_src_used(disp_src_used), .disp_src_tag(disp_src_tag), .disp_src_rdy(disp_src_rdy),
    .disp_pd(disp_pd), .disp_regwr(disp_regwr), .disp_rob(disp_rob), .disp_payload(disp_payload),
    .disp_stall(disp_stall), .disp_full(disp_full), .count(count),
    .cdb_valid(cdb_valid), .cdb_regwr(cdb_regwr), .cdb_tag(cdb_tag), .issue_stall(issue_stall),
    .issue_valid(issue_valid), .issue_rob(issue_rob), .issue_pd(issue_pd), .issue_regwr(issue_regwr),
    .issue_src_tag(issue_src_tag), .issue_payload(issue_payload));

  serial_issue_queue #(.SERIALIZE(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
    .disp_src_used(disp_src_used), .disp_src_tag(disp_src_tag), .disp_src_rdy(disp_src_rdy),
    .disp_pd(disp_pd), .disp_regwr(disp_regwr), .disp_rob(disp_rob), .disp_payload(disp_payload),
    .disp_stall(disp_stall), .disp_full(disp_full0), .count(count0),
    .cdb_valid(cdb_valid), .cdb_regwr(cdb_regwr), .cdb_tag(cdb_tag), .issue_stall(issue_stall),
    .issue_valid(issue_valid0), .issue_rob(issue_rob0), .issue_pd(issue_pd0), .issue_regwr(issue_regwr0),
    .issue_src_tag(issue_src_tag0), .issue_payload(issue_payload0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; disp_stall = 0; issue_stall = 0;
    disp_valid = '0; disp_regwr = '0; disp_src_used = '0; disp_src_rdy = '0;
    disp_src_tag = '0; disp_pd = '0; disp_rob = '0; disp_payload = '0;
    cdb_valid = '0; cdb_regwr = '0; cdb_tag = '0;
  endtask

  task automatic set_slot(input int s, input logic [5:0] rob, input logic used1,
                          input logic [5:0] tag1, input logic rdy1);
    disp_valid[s] = 1'b1;
    disp_regwr[s] = 1'b1;
    disp_rob[s*6 +: 6] = rob;
    disp_pd[s*6 +: 6] = rob ^ 6'h3F;
    disp_payload[s*24 +: 24] = {rob, rob, rob, 6'h2A};
    disp_src_used[2*s] = 1'b0;
    disp_src_used[2*s+1] = used1;
    disp_src_tag[(2*s+1)*6 +: 6] = tag1;
    disp_src_rdy[2*s+1] = rdy1;
  endtask

  task automatic push_slots();
    for (int s = 0; s < DISP_W; s++)
      if (disp_valid[s]) exp_q.push_back(disp_rob[s*6 +: 6]);
  endtask

  task automatic done_pulse();
    cdb_valid = 5'b10000;
    tick();
    cdb_valid = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    tick(); tick();
    n_checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %0b want 0", issue_valid); else n_pass++;
    n_checks++; if (disp_full !== 1'b0) $display("FAIL reset_disp_full: got %0b want 0", disp_full); else n_pass++;
    n_checks++; if (issue_rob !== 6'd0 || issue_payload !== 24'd0) $display("FAIL reset_issue_fields: got rob %0h pay %0h want 0", issue_rob, issue_payload); else n_pass++;
    rst = 1;
    tick();
  endtask

  task automatic test_basic();
    set_slot(0, 6'h01, 1'b0, 6'h00, 1'b0);
    set_slot(2, 6'h02, 1'b0, 6'h00, 1'b0);
    push_slots();
    tick();
    clear_inputs();
    n_checks++; if (count !== 5'd2 || issue_valid !== 1'b0) $display("FAIL basic_enq: got count %0d iv %0b want 2 0", count, issue_valid); else n_pass++;
    tick();
    exp_rob = exp_q.pop_front();
    n_checks++; if (issue_valid !== 1'b1 || issue_rob !== exp_rob || count !== 5'd1) $display("FAIL basic_issue0: got iv %0b rob %0h cnt %0d want 1 %0h 1", issue_valid, issue_rob, count, exp_rob); else n_pass++;
    n_checks++; if (issue_payload !== {exp_rob, exp_rob, exp_rob, 6'h2A} || issue_pd !== (exp_rob ^ 6'h3F)) $display("FAIL basic_fields: got pay %0h pd %0h", issue_payload, issue_pd); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL basic_serial_hold: got iv %0b want 0 (cycle %0d)", issue_valid, i); else n_pass++;
    end
    done_pulse();
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL basic_done_cycle: got iv %0b want 0", issue_valid); else n_pass++;
    tick();
    exp_rob = exp_q.pop_front();
    n_checks++; if (issue_valid !== 1'b1 || issue_rob !== exp_rob || count !== 5'd0) $display("FAIL basic_issue2: got iv %0b rob %0h cnt %0d want 1 %0h 0", issue_valid, issue_rob, count, exp_rob); else n_pass++;
    done_pulse();
    n_checks++; if (u_dut.inflight !== 1'b0) $display("FAIL basic_inflight: got %0b want 0", u_dut.inflight); else n_pass++;
  endtask

  task automatic test_wakeup();
    set_slot(0, 6'h10, 1'b1, 6'h15, 1'b0);
    push_slots();
    tick();
    clear_inputs();
    tick(); tick();
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL wake_early: got iv %0b want 0", issue_valid); else n_pass++;
    cdb_valid[2] = 1'b1; cdb_regwr[2] = 1'b0; cdb_tag[2*6 +: 6] = 6'h15;
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL wake_noregwr: got iv %0b want 0 (cycle %0d)", issue_valid, i); else n_pass++;
    end
    cdb_valid[2] = 1'b1; cdb_regwr[2] = 1'b1; cdb_tag[2*6 +: 6] = 6'h15;
    tick();
    clear_inputs();
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL wake_same_cycle: got iv %0b want 0", issue_valid); else n_pass++;
    tick();
    exp_rob = exp_q.pop_front();
    n_checks++; if (issue_valid !== 1'b1 || issue_rob !== exp_rob) $display("FAIL wake_issue: got iv %0b rob %0h want 1 %0h", issue_valid, issue_rob, exp_rob); else n_pass++;
    n_checks++; if (issue_src_tag[11:6] !== 6'h15) $display("FAIL wake_src_tag: got %0h want 15", issue_src_tag[11:6]); else n_pass++;
    done_pulse();
  endtask

  task automatic test_full();
    logic [5:0] rob;
    rob = 6'h20;
    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < ((c == 4) ? 2 : 3); s++) begin
        set_slot(s, rob, 1'b1, 6'h3F, 1'b0);
        rob = rob + 6'd1;
      end
      push_slots();
      tick();
      clear_inputs();
    end
    n_checks++; if (count !== 5'd14) $display("FAIL full_fill: got count %0d want 14", count); else n_pass++;
    for (int s = 0; s < 3; s++) set_slot(s, 6'h2E + 6'(s), 1'b1, 6'h3F, 1'b0);
    #1;
    n_checks++; if (disp_full !== 1'b1) $display("FAIL full_flag3: got %0b want 1", disp_full); else n_pass++;
    tick();
    clear_inputs();
    n_checks++; if (count !== 5'd14 || u_dut.tail !== 4'd1) $display("FAIL full_reject: got count %0d tail %0d want 14 1", count, u_dut.tail); else n_pass++;
    set_slot(0, 6'h2E, 1'b1, 6'h3F, 1'b0);
    set_slot(1, 6'h2F, 1'b1, 6'h3F, 1'b0);
    #1;
    n_checks++; if (disp_full !== 1'b0) $display("FAIL full_flag2: got %0b want 0", disp_full); else n_pass++;
    push_slots();
    tick();
    clear_inputs();
    n_checks++; if (count !== 5'd16 || u_dut.tail !== 4'd3 || u_dut.head !== 4'd3) $display("FAIL full_wrap: got count %0d tail %0d head %0d want 16 3 3", count, u_dut.tail, u_dut.head); else n_pass++;
  endtask

  task automatic test_full_issue();
    cdb_valid[0] = 1'b1; cdb_regwr[0] = 1'b1; cdb_tag[5:0] = 6'h3F;
    tick();
    clear_inputs();
    set_slot(0, 6'h3A, 1'b0, 6'h00, 1'b0);
    #1;
    n_checks++; if (disp_full !== 1'b1) $display("FAIL fullissue_flag: got %0b want 1", disp_full); else n_pass++;
    tick();
    clear_inputs();
    exp_rob = exp_q.pop_front();
    n_checks++; if (issue_valid !== 1'b1 || issue_rob !== exp_rob || count !== 5'd15) $display("FAIL fullissue: got iv %0b rob %0h cnt %0d want 1 %0h 15", issue_valid, issue_rob, count, exp_rob); else n_pass++;
  endtask

  task automatic test_flush();
    done_pulse();
    n_checks++; if (u_dut.inflight !== 1'b0 || issue_valid !== 1'b0) $display("FAIL flush_pre: got inflight %0b iv %0b want 0 0", u_dut.inflight, issue_valid); else n_pass++;
    flush = 1'b1;
    set_slot(0, 6'h3B, 1'b0, 6'h00, 1'b0);
    cdb_valid[4] = 1'b1;
    tick();
    clear_inputs();
    exp_q.delete();
    n_checks++; if (count !== 5'd0 || issue_valid !== 1'b0 || u_dut.inflight !== 1'b0) $display("FAIL flush_state: got cnt %0d iv %0b inflight %0b want 0 0 0", count, issue_valid, u_dut.inflight); else n_pass++;
    n_checks++; if (u_dut.head !== 4'd0 || u_dut.tail !== 4'd0 || count0 !== 5'd0) $display("FAIL flush_ptrs: got head %0d tail %0d cnt0 %0d want 0 0 0", u_dut.head, u_dut.tail, count0); else n_pass++;
    set_slot(0, 6'h30, 1'b0, 6'h00, 1'b0);
    push_slots();
    tick();
    clear_inputs();
    n_checks++; if (u_dut.ent_rob[0] !== 6'h30 || u_dut.tail !== 4'd1) $display("FAIL flush_land0: got rob0 %0h tail %0d want 30 1", u_dut.ent_rob[0], u_dut.tail); else n_pass++;
    tick();
    exp_rob = exp_q.pop_front();
    n_checks++; if (issue_valid !== 1'b1 || issue_rob !== exp_rob) $display("FAIL flush_after_issue: got iv %0b rob %0h want 1 %0h", issue_valid, issue_rob, exp_rob); else n_pass++;
    done_pulse();
  endtask

  task automatic test_ser0();
    exp0_q.delete();
    for (int s = 0; s < 3; s++) begin
      set_slot(s, 6'h21 + 6'(s), 1'b0, 6'h00, 1'b0);
      exp0_q.push_back(6'h21 + 6'(s));
    end
    tick();
    clear_inputs();
    set_slot(0, 6'h24, 1'b0, 6'h00, 1'b0);
    exp0_q.push_back(6'h24);
    tick();
    clear_inputs();
    exp_rob = exp0_q.pop_front();
    n_checks++; if (issue_valid0 !== 1'b1 || issue_rob0 !== exp_rob) $display("FAIL ser0_first: got iv %0b rob %0h want 1 %0h", issue_valid0, issue_rob0, exp_rob); else n_pass++;
    issue_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (issue_valid0 !== 1'b0) $display("FAIL ser0_stall: got iv %0b want 0 (cycle %0d)", issue_valid0, i); else n_pass++;
    end
    issue_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_rob = (exp0_q.size() != 0) ? exp0_q.pop_front() : 6'h00;
      n_checks++; if (issue_valid0 !== 1'b1 || issue_rob0 !== exp_rob) $display("FAIL ser0_seq: got iv %0b rob %0h want 1 %0h (pulse %0d)", issue_valid0, issue_rob0, exp_rob, i); else n_pass++;
    end
    tick();
    n_checks++; if (issue_valid0 !== 1'b0 || count0 !== 5'd0) $display("FAIL ser0_drain: got iv %0b cnt %0d want 0 0", issue_valid0, count0); else n_pass++;
  endtask

  task automatic test_async_reset();
    set_slot(0, 6'h33, 1'b1, 6'h01, 1'b0);
    tick();
    clear_inputs();
    n_checks++; if (count0 !== 5'd1) $display("FAIL areset_pre: got cnt0 %0d want 1", count0); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (count !== 5'd0 || count0 !== 5'd0 || issue_valid !== 1'b0 || u_dut.inflight !== 1'b0) $display("FAIL areset: got cnt %0d cnt0 %0d iv %0b inflight %0b want 0 0 0 0", count, count0, issue_valid, u_dut.inflight); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_full_issue();
    test_flush();
    test_ser0();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_issue_queue.md
# serial_issue_queue

Parametrised in-order issue queue for serialising instructions (CSR access, CSR exchange, and other privileged ops). It sits between rename/dispatch and the privileged execute unit. It accepts up to DISP_W compacted instructions per cycle and wakes source operands from the CDB. It issues strictly oldest-first, and in SERIALIZE mode allows only one issued op in flight until the execute unit signals completion. Compared with the previous CSR queue, it adds generic width/depth/CDB parameters, an exact occupancy count, all-or-nothing dispatch against true free space, and a selectable serialisation mode.

## Interface
- DEPTH, 16, entry count; power of two, at least 4
- DISP_W, 3, dispatch slots per cycle
- CDB_W, 5, CDB broadcast ports
- PTAG_W, 6, physical register tag width
- ROB_W, 6, ROB tag width
- PAY_W, 24, opaque payload (csr_addr, conf, csrWr, …) carried unchanged
- SERIALIZE, 1, 1 = one op in flight, gated by done; 0 = issue every eligible cycle
- DONE_PORT, 4, index of the CDB port whose ready pulse counts as done in SERIALIZE mode
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  clear queue and in-flight state
- disp_valid  in  DISP_W  per-slot instruction valid (already filtered by type and pc-ready)
- disp_src_used  in  2*DISP_W  per-slot, per-source operand used
- disp_src_tag  in  2*DISP_W*PTAG_W  source physical tags
- disp_src_rdy  in  2*DISP_W  source ready at rename
- disp_pd  in  DISP_W*PTAG_W  destination tag
- disp_regwr  in  DISP_W  writes register
- disp_rob  in  DISP_W*ROB_W  ROB tag
- disp_payload  in  DISP_W*PAY_W  payload
- disp_stall  in  1  upstream stall; no enqueue this cycle
- disp_full  out  1  free slots < popcount(disp_valid)
- count  out  $clog2(DEPTH)+1  occupancy
- cdb_valid, cdb_regwr  in  CDB_W each  broadcast valid, writes a register
- cdb_tag  in  CDB_W*PTAG_W  broadcast destination tag
- issue_stall  in  1  execute unit cannot accept
- issue_valid  out  1  registered issue pulse
- issue_rob, issue_pd, issue_regwr, issue_src_tag, issue_payload  out  widths as dispatch  issued entry fields

## Operation
- Storage: circular buffer with head (oldest) and tail pointers of $clog2(DEPTH) bits that wrap naturally, plus a separate count register. Empty is count==0; full is count==DEPTH.
- Dispatch compaction: valid slots are written in slot order to tail, tail+1, … with no gaps. Tail advances by popcount(disp_valid).
- Enqueue condition is !flush && !disp_stall && !disp_full && any disp_valid. The accept is all-or-nothing; there is no partial accept.
- Source readiness at write: a source is ready if it is unused, or disp_src_rdy is set, or any CDB port has valid && regwr && tag==src in that same cycle.
- Wakeup: every cycle, each occupied entry's source becomes ready on any matching CDB port with valid && regwr. Free entries never wake.
- Issue condition: count!=0, both head sources ready, !issue_stall, and inflight==0 (SERIALIZE=1 only).
- On issue: the output registers load the head fields, issue_valid is 1 for that cycle, the head entry is freed, and head advances by 1. With SERIALIZE=1, inflight is set to 1.
- Done: cdb_valid[DONE_PORT] clears inflight, independent of cdb_regwr. A done that arrives while inflight==0 is ignored.
- count_next = count + accepted − issued. Enqueue and issue in the same cycle are legal, including when count==DEPTH−1.
- flush has priority over all other activity. It clears valid bits, pointers, count, inflight and issue_valid.

## Timing
- Reset values:
  - all outputs 0, except disp_full, which is 0 when disp_valid==0
  - count=0, head=tail=0, inflight=0
- An enqueued entry is issue-eligible no earlier than the next cycle. There is no bypass from dispatch to issue.
- Wakeup latency: a CDB match in cycle N makes the entry issuable in N+1, so issue_valid rises at the end of N+1.
- disp_full is combinational on count and disp_valid. The count used is the registered value; an issue happening in the same cycle is not credited.
- SERIALIZE=1: after an issue in cycle N, the next issue is possible at the earliest in cycle M+1, where M is the done cycle (M ≥ N+1).
- issue_stall only holds the head entry; wakeups continue while stalled.
- An asynchronous reset mid-operation drops everything immediately, with no drain.

## Test plan
- Reset, then dispatch slots {0,2} valid with all sources ready. Required: count==2; the slot-0 entry issues in cycle +1 and the slot-2 entry issues only after done on port 4 (SERIALIZE=1).
- Head src1 tag 0x15 not ready, then cdb port 2 broadcasts 0x15 with regwr=1. Required: issue_valid exactly one cycle later, and no issue before. The same broadcast with regwr=0 must never wake the entry.
- Fill to count==14, then dispatch 3 valid: disp_full=1 and nothing is written. Dispatch 2 valid: accepted, count==16, tail wraps to head.
- count==16 with the head eligible, and dispatch 1 valid in the same cycle. Required: disp_full=1 and no enqueue; the head issues and count==15.
- Flush asserted in the same cycle as an enqueue, an issue and a done. Required: count==0, issue_valid==0 the next cycle, inflight cleared, and the next dispatch lands at index 0.
- SERIALIZE=0 with 4 ready entries: four consecutive issue_valid pulses in oldest-first ROB order. issue_stall held for 2 cycles in the middle delays them without loss.
